hdlc_tx_sched: RTL

//  Round-robin scheduler sharing the single HDLC TX byte path (tx RAM reader + serializer) among NCH

---
 rtl/hdlc_pkg.sv | 16 +
 rtl/rr_pick.sv | 34 +++
 rtl/hdlc_tx_sched.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/hdlc_pkg.sv
// Shared HDLC TX definitions: scheduler state encoding and default widths/timing.
package hdlc_pkg;

    localparam int unsigned HDLC_GAP_DEF = 84;
    localparam int unsigned HDLC_LEN_W   = 10;
    localparam int unsigned HDLC_ADDR_W  = 9;

    localparam int unsigned ST_W = 3;

    localparam logic [ST_W-1:0] S_IDLE   = 3'd0;
    localparam logic [ST_W-1:0] S_ARB    = 3'd1;
    localparam logic [ST_W-1:0] S_LAUNCH = 3'd2;
    localparam logic [ST_W-1:0] S_WAIT   = 3'd3;
    localparam logic [ST_W-1:0] S_GAP    = 3'd4;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin select: first set request at or above ptr, wrapping at NCH-1 -> 0.
module rr_pick #(
    parameter int unsigned NCH   = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic [NCH-1:0]   req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NCH-1:0]   win_oh,
    output logic [PTR_W-1:0] win_idx,
    output logic             any
);

    always_comb begin
        int unsigned idx;
        logic        found;
        win_oh  = '0;
        win_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int unsigned k = 0; k < NCH; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= NCH) begin
                idx = idx - NCH;
            end
            if (!found && req[idx]) begin
                found        = 1'b1;
                win_oh[idx]  = 1'b1;
                win_idx      = PTR_W'(idx);
            end
        end
        any = |req;
    end

endmodule

// File: rtl/hdlc_tx_sched.sv
// Round-robin scheduler sharing the HDLC TX byte path among NCH frame sources,
// with completion timeout and a fixed inter-frame flag gap.
module hdlc_tx_sched
    import hdlc_pkg::*;
#(
    parameter int unsigned NCH     = 4,
    parameter int unsigned LEN_W   = HDLC_LEN_W,
    parameter int unsigned ADDR_W  = HDLC_ADDR_W,
    parameter int unsigned GAP_CYC = HDLC_GAP_DEF,
    parameter int unsigned TMO_CYC = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NCH-1:0]        req,
    input  logic [NCH*LEN_W-1:0]  req_len,
    input  logic [NCH*ADDR_W-1:0] req_base,
    output logic [NCH-1:0]        grant,
    output logic                  tx_start,
    output logic [LEN_W-1:0]      tx_len,
    output logic [ADDR_W-1:0]     tx_base,
    input  logic                  tx_done,
    output logic                  busy,
    output logic [2:0]            cur_ch,
    output logic                  err_tmo,
    output logic                  err_zlen
);

    localparam int unsigned PTR_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned TMO_W = $clog2(TMO_CYC) + 1;
    localparam int unsigned GAP_W = $clog2(GAP_CYC) + 1;

    logic [ST_W-1:0]   state_q,    state_d;
    logic [PTR_W-1:0]  rr_ptr_q,   rr_ptr_d;
    logic [PTR_W-1:0]  cur_idx_q,  cur_idx_d;
    logic [TMO_W-1:0]  tmo_cnt_q,  tmo_cnt_d;
    logic [GAP_W-1:0]  gap_cnt_q,  gap_cnt_d;
    logic [LEN_W-1:0]  tx_len_q,   tx_len_d;
    logic [ADDR_W-1:0] tx_base_q,  tx_base_d;
    logic [NCH-1:0]    grant_q,    grant_d;
    logic              tx_start_q, tx_start_d;
    logic              busy_q,     busy_d;
    logic              err_tmo_q,  err_tmo_d;
    logic              err_zlen_q, err_zlen_d;

    logic [NCH-1:0]    win_oh;
    logic [PTR_W-1:0]  win_idx;
    logic              win_any;
    logic [LEN_W-1:0]  win_len;
    logic [ADDR_W-1:0] win_base;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (32'(p) == NCH - 1) ? '0 : p + PTR_W'(1);
    endfunction

    rr_pick #(
        .NCH   (NCH),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req     (req),
        .ptr     (rr_ptr_q),
        .win_oh  (win_oh),
        .win_idx (win_idx),
        .any     (win_any)
    );

    assign win_len  = req_len[32'(win_idx) * LEN_W +: LEN_W];
    assign win_base = req_base[32'(win_idx) * ADDR_W +: ADDR_W];

    // Next state plus look-ahead of every output so the registered copies line up with the state.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        cur_idx_d  = cur_idx_q;
        tmo_cnt_d  = tmo_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        tx_len_d   = tx_len_q;
        tx_base_d  = tx_base_q;
        grant_d    = '0;
        tx_start_d = 1'b0;
        err_tmo_d  = 1'b0;
        err_zlen_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    state_d = S_ARB;
                end
            end
            S_ARB: begin
                if (!win_any) begin
                    state_d = S_IDLE;
                end else begin
                    cur_idx_d = win_idx;
                    tx_len_d  = win_len;
                    tx_base_d = win_base;
                    grant_d   = win_oh;
                    if (win_len == '0) begin
                        err_zlen_d = 1'b1;
                        rr_ptr_d   = ptr_inc(win_idx);
                        state_d    = S_IDLE;
                    end else begin
                        tx_start_d = 1'b1;
                        state_d    = S_LAUNCH;
                    end
                end
            end
            S_LAUNCH: begin
                rr_ptr_d  = ptr_inc(cur_idx_q);
                tmo_cnt_d = '0;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                // A done coinciding with the timeout wins: the frame completed.
                if (tx_done) begin
                    gap_cnt_d = '0;
                    state_d   = S_GAP;
                end else if (tmo_cnt_q == TMO_W'(TMO_CYC - 1)) begin
                    err_tmo_d = 1'b1;
                    gap_cnt_d = '0;
                    state_d   = S_GAP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_W'(GAP_CYC - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            cur_idx_q  <= '0;
            tmo_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            tx_len_q   <= '0;
            tx_base_q  <= '0;
            grant_q    <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            err_tmo_q  <= 1'b0;
            err_zlen_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            cur_idx_q  <= cur_idx_d;
            tmo_cnt_q  <= tmo_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            tx_len_q   <= tx_len_d;
            tx_base_q  <= tx_base_d;
            grant_q    <= grant_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            err_tmo_q  <= err_tmo_d;
            err_zlen_q <= err_zlen_d;
        end
    end

    assign grant    = grant_q;
    assign tx_start = tx_start_q;
    assign tx_len   = tx_len_q;
    assign tx_base  = tx_base_q;
    assign busy     = busy_q;
    assign cur_ch   = 3'(cur_idx_q);
    assign err_tmo  = err_tmo_q;
    assign err_zlen = err_zlen_q;

endmodule
